// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array and its feeder.
package systolic_pkg;

   localparam int unsigned ARRAY_SIZE_DEF = 2;
   localparam int unsigned DATA_WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } feeder_state_e;

   // Width of the wavefront counter: must hold 0..2N-1.
   function automatic int unsigned skew_width(input int unsigned n);
      return (n < 1) ? 1 : $clog2(2 * n);
   endfunction

endpackage

// File: rtl/skew_lane_mux.sv
// Picks element [t - LANE] of one buffered lane, or zero when outside 0..N-1.
module skew_lane_mux
   import systolic_pkg::*;
#(
   parameter int unsigned N    = ARRAY_SIZE_DEF,
   parameter int unsigned W    = DATA_WIDTH_DEF,
   parameter int unsigned LANE = 0,
   parameter int unsigned CW   = skew_width(N)
) (
   input  logic [N*W-1:0] elems_i,
   input  logic [CW-1:0]  t_i,
   output logic [W-1:0]   elem_c_o
);

   localparam int unsigned DW = CW + 1;

   logic [DW-1:0] diff_c;

   // Extra MSB flags t < LANE instead of letting the subtraction wrap.
   always_comb begin
      diff_c   = {1'b0, t_i} - DW'(LANE);
      elem_c_o = '0;
      if (!diff_c[CW]) begin
         for (int e = 0; e < int'(N); e++) begin
            if (diff_c[CW-1:0] == CW'(e)) elem_c_o = elems_i[e*W +: W];
         end
      end
   end

endmodule

// File: rtl/systolic_feeder.sv
// Loads N x N operands A (by column) and B (by row), then streams skewed
// wavefronts into the systolic array, drains, and pulses done.
// Optional: define SYSTOLIC_FEEDER_CLR_EN to add the array_clr output.
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int unsigned ARRAY_SIZE   = ARRAY_SIZE_DEF,
   parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int unsigned DRAIN_CYCLES = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             s_valid,
   output logic                             s_ready,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] s_a_col,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] s_b_row,
   output logic [ARRAY_SIZE*DATA_WIDTH-1:0] input_left,
   output logic [ARRAY_SIZE*DATA_WIDTH-1:0] input_top,
   output logic                             busy,
   output logic                             done
`ifdef SYSTOLIC_FEEDER_CLR_EN
   ,
   output logic                             array_clr
`endif
);

   localparam int unsigned N   = ARRAY_SIZE;
   localparam int unsigned W   = DATA_WIDTH;
   localparam int unsigned VW  = N * W;
   localparam int unsigned CW  = skew_width(N);
   localparam int unsigned DCW = $clog2(DRAIN_CYCLES + 1);

   feeder_state_e state_q, state_d;
   logic [CW-1:0]  beat_q, beat_d;
   logic [CW-1:0]  t_q, t_d;
   logic [DCW-1:0] drain_q, drain_d;
   logic [VW-1:0]  left_q, left_d, top_q, top_d;
   logic           busy_q, busy_d, done_q, done_d, ready_q, ready_d;
`ifdef SYSTOLIC_FEEDER_CLR_EN
   logic           clr_q, clr_d;
`endif

   // a_q[i] holds row i of A, b_q[j] holds column j of B; element k at k*W.
   logic [N-1:0][VW-1:0] a_q, b_q;
   logic [VW-1:0]        left_c, top_c;
   logic                 load_fire_c;

   assign load_fire_c = (state_q == LOAD) && s_valid;

   // One skew mux per lane for each edge of the array.
   for (genvar g = 0; g < int'(N); g++) begin : g_lane
      skew_lane_mux #(.N(N), .W(W), .LANE(g), .CW(CW)) u_left (
         .elems_i  (a_q[g]),
         .t_i      (t_q),
         .elem_c_o (left_c[g*W +: W])
      );
      skew_lane_mux #(.N(N), .W(W), .LANE(g), .CW(CW)) u_top (
         .elems_i  (b_q[g]),
         .t_i      (t_q),
         .elem_c_o (top_c[g*W +: W])
      );
   end

   // Operand buffers; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (load_fire_c) begin
         for (int i = 0; i < int'(N); i++) begin
            for (int k = 0; k < int'(N); k++) begin
               if (beat_q == CW'(k)) begin
                  a_q[i][k*W +: W] <= s_a_col[i*W +: W];
                  b_q[i][k*W +: W] <= s_b_row[i*W +: W];
               end
            end
         end
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      t_d     = t_q;
      drain_d = drain_q;
      left_d  = '0;
      top_d   = '0;
      done_d  = 1'b0;
`ifdef SYSTOLIC_FEEDER_CLR_EN
      clr_d   = 1'b0;
`endif
      case (state_q)
         LOAD: begin
            if (s_valid) begin
               if (beat_q == CW'(N - 1)) begin
                  beat_d  = '0;
                  t_d     = '0;
                  state_d = STREAM;
`ifdef SYSTOLIC_FEEDER_CLR_EN
                  clr_d   = 1'b1;
`endif
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         STREAM: begin
            left_d = left_c;
            top_d  = top_c;
            if (t_q == CW'(2 * N - 2)) begin
               t_d     = '0;
               drain_d = '0;
               state_d = DRAIN;
            end else begin
               t_d = t_q + 1'b1;
            end
         end
         DRAIN: begin
            if (drain_q == DCW'(DRAIN_CYCLES - 1)) begin
               drain_d = '0;
               done_d  = 1'b1;
               state_d = LOAD;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         default: state_d = LOAD;
      endcase
      busy_d  = (state_d != LOAD);
      ready_d = (state_d == LOAD);
   end

   // State, counters and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= LOAD;
         beat_q  <= '0;
         t_q     <= '0;
         drain_q <= '0;
         left_q  <= '0;
         top_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
`ifdef SYSTOLIC_FEEDER_CLR_EN
         clr_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         t_q     <= t_d;
         drain_q <= drain_d;
         left_q  <= left_d;
         top_q   <= top_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ready_q <= ready_d;
`ifdef SYSTOLIC_FEEDER_CLR_EN
         clr_q   <= clr_d;
`endif
      end
   end

   assign s_ready    = ready_q;
   assign input_left = left_q;
   assign input_top  = top_q;
   assign busy       = busy_q;
   assign done       = done_q;
`ifdef SYSTOLIC_FEEDER_CLR_EN
   assign array_clr  = clr_q;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder (N=2, W=4, DRAIN_CYCLES=4).
module tb_systolic_feeder;

   localparam int unsigned N = 2;
   localparam int unsigned W = 4;
   localparam int unsigned D = 4;

   typedef struct {
      logic [7:0]      a0, a1, b0, b1;
      logic [2:0][7:0] el;
      logic [2:0][7:0] et;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic [7:0] s_a_col = '0;
   logic [7:0] s_b_row = '0;
   logic [7:0] input_left, input_top;
   logic       busy, done;
`ifdef SYSTOLIC_FEEDER_CLR_EN
   logic       array_clr;
`endif

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int runs = 0;

   systolic_feeder #(.ARRAY_SIZE(N), .DATA_WIDTH(W), .DRAIN_CYCLES(D)) dut (
      .clk        (clk),
      .reset      (reset),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_a_col    (s_a_col),
      .s_b_row    (s_b_row),
      .input_left (input_left),
      .input_top  (input_top),
      .busy       (busy),
      .done       (done)
`ifdef SYSTOLIC_FEEDER_CLR_EN
      ,
      .array_clr  (array_clr)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (done) done_cnt++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [7:0] a0, a1, b0, b1,
                               input logic [23:0] el, et);
      vec_t v;
      v.a0 = a0; v.a1 = a1; v.b0 = b0; v.b1 = b1;
      v.el = el; v.et = et;
      return v;
   endfunction

   // Expected wavefronts from the matrix definition: left lane i at time t
   // carries A[i][t-i], top lane j carries B[t-j][j], zero outside range.
   function automatic vec_t model(input logic [7:0] a0, a1, b0, b1);
      vec_t v;
      logic [1:0][7:0] ac, br;
      int am[2][2];
      int bm[2][2];
      ac = {a1, a0};
      br = {b1, b0};
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 2; i++) begin
            am[i][k] = int'(ac[k][i*4 +: 4]);
            bm[k][i] = int'(br[k][i*4 +: 4]);
         end
      end
      v.a0 = a0; v.a1 = a1; v.b0 = b0; v.b1 = b1;
      v.el = '0;
      v.et = '0;
      for (int t = 0; t < 3; t++) begin
         for (int ln = 0; ln < 2; ln++) begin
            int k;
            k = t - ln;
            if (k >= 0 && k < 2) begin
               v.el[t][ln*4 +: 4] = 4'(am[ln][k]);
               v.et[t][ln*4 +: 4] = 4'(bm[k][ln]);
            end
         end
      end
      return v;
   endfunction

   // Present both beats; 'gap' idle cycles between them; 'now' drives beat 0
   // in the current slot (used for the done cycle).
   task automatic load(input vec_t v, input int gap, input bit now);
      if (!now) @(negedge clk);
      chk("load_ready0", 32'(s_ready), 32'd1);
      s_valid = 1'b1; s_a_col = v.a0; s_b_row = v.b0;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         s_valid = 1'b0; s_a_col = 8'($urandom); s_b_row = 8'($urandom);
         chk("gap_ready", 32'(s_ready), 32'd1);
         chk("gap_idle", 32'(busy), 32'd0);
      end
      @(negedge clk);
      chk("load_ready1", 32'(s_ready), 32'd1);
      s_valid = 1'b1; s_a_col = v.a1; s_b_row = v.b1;
   endtask

   task automatic drive_junk(input bit junk);
      s_valid = junk;
      s_a_col = 8'($urandom);
      s_b_row = 8'($urandom);
   endtask

   // Check everything from the cycle after the last beat through done.
   task automatic stream(input vec_t v, input bit junk, input string tag);
      @(negedge clk);
      drive_junk(junk);
      chk($sformatf("%s_pre_ready", tag), 32'(s_ready), 32'd0);
      chk($sformatf("%s_pre_busy", tag), 32'(busy), 32'd1);
      chk($sformatf("%s_pre_left", tag), 32'(input_left), 32'd0);
`ifdef SYSTOLIC_FEEDER_CLR_EN
      chk($sformatf("%s_clr_on", tag), 32'(array_clr), 32'd1);
`endif
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         drive_junk(junk);
         chk($sformatf("%s_left_wf%0d", tag, t), 32'(input_left), 32'(v.el[t]));
         chk($sformatf("%s_top_wf%0d", tag, t), 32'(input_top), 32'(v.et[t]));
         chk($sformatf("%s_busy_wf%0d", tag, t), 32'(busy), 32'd1);
         chk($sformatf("%s_ready_wf%0d", tag, t), 32'(s_ready), 32'd0);
`ifdef SYSTOLIC_FEEDER_CLR_EN
         chk($sformatf("%s_clr_off%0d", tag, t), 32'(array_clr), 32'd0);
`endif
      end
      for (int d = 0; d < int'(D) - 1; d++) begin
         @(negedge clk);
         drive_junk(junk);
         chk($sformatf("%s_drain_out%0d", tag, d), 32'({input_left, input_top}), 32'd0);
         chk($sformatf("%s_drain_done%0d", tag, d), 32'(done), 32'd0);
         chk($sformatf("%s_drain_busy%0d", tag, d), 32'(busy), 32'd1);
      end
      @(negedge clk);
      s_valid = 1'b0;
      chk($sformatf("%s_done", tag), 32'(done), 32'd1);
      chk($sformatf("%s_done_ready", tag), 32'(s_ready), 32'd1);
      chk($sformatf("%s_done_busy", tag), 32'(busy), 32'd0);
      chk($sformatf("%s_done_out", tag), 32'({input_left, input_top}), 32'd0);
      runs++;
   endtask

   initial begin
      vec_t tbl[3];
      vec_t v;
      int   dc;

      tbl[0] = mk(8'h21, 8'h21, 8'h21, 8'h21, {8'h20, 8'h21, 8'h01}, {8'h20, 8'h21, 8'h01});
      tbl[1] = mk(8'h43, 8'h65, 8'h87, 8'hA9, {8'h60, 8'h45, 8'h03}, {8'hA0, 8'h89, 8'h07});
      tbl[2] = mk(8'hF0, 8'h0F, 8'h1E, 8'hC3, {8'h00, 8'hFF, 8'h00}, {8'hC0, 8'h13, 8'h0E});

      // Reset values
      #12;
      chk("rst_left", 32'(input_left), 32'd0);
      chk("rst_top", 32'(input_top), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ready", 32'(s_ready), 32'd1);
`ifdef SYSTOLIC_FEEDER_CLR_EN
      chk("rst_clr", 32'(array_clr), 32'd0);
`endif
      @(negedge clk);
      reset = 1'b0;

      // Table-driven vectors
      for (int i = 0; i < 3; i++) begin
         load(tbl[i], 0, 1'b0);
         stream(tbl[i], 1'b0, $sformatf("tbl%0d", i));
      end

      // Backpressure: valid held with changing data while streaming
      load(tbl[1], 0, 1'b0);
      stream(tbl[1], 1'b1, "bp");
      load(tbl[0], 0, 1'b0);
      stream(tbl[0], 1'b0, "after_bp");

      // Gapped loading: valid 1,0,0,1
      load(tbl[2], 2, 1'b0);
      stream(tbl[2], 1'b0, "gap");

      // Back-to-back: next beat 0 presented in the done cycle
      load(tbl[0], 0, 1'b0);
      stream(tbl[0], 1'b0, "b2b_a");
      load(tbl[1], 0, 1'b1);
      stream(tbl[1], 1'b0, "b2b_b");

      // Randomized matrices against the model
      repeat (20) begin
         v = model(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
         load(v, int'($urandom_range(0, 2)), 1'b0);
         stream(v, 1'($urandom_range(0, 1)), "rnd");
      end

      // Reset mid-STREAM, just after wavefront 1
      load(tbl[1], 0, 1'b0);
      @(negedge clk); s_valid = 1'b0;
      @(negedge clk);
      chk("mid_wf0", 32'(input_left), 32'(tbl[1].el[0]));
      @(negedge clk);
      chk("mid_wf1", 32'(input_left), 32'(tbl[1].el[1]));
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_left", 32'(input_left), 32'd0);
      chk("mid_rst_top", 32'(input_top), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      dc = done_cnt;
      repeat (2 * N + D + 4) @(negedge clk);
      chk("mid_rst_no_done", 32'(done_cnt), 32'(dc));
      chk("mid_rst_ready", 32'(s_ready), 32'd1);
      chk("mid_rst_idle", 32'(busy), 32'd0);

      // A lone beat before reset must not count toward the next matrix
      @(negedge clk);
      s_valid = 1'b1; s_a_col = 8'h77; s_b_row = 8'h77;
      @(negedge clk);
      s_valid = 1'b0;
      #2 reset = 1'b1;
      #2 reset = 1'b0;
      load(tbl[2], 0, 1'b0);
      stream(tbl[2], 1'b0, "post_rst");

      repeat (3) @(negedge clk);
      chk("done_total", 32'(done_cnt), 32'(runs));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
Transmit-side front end for the `systolic` array. Accepts matrix A one column per beat and matrix B one row per beat over a valid/ready handshake, buffering both N×N operands. It then drives the skewed wavefronts onto the array's `input_left` / `input_top`, waits a drain interval and pulses `done`. This replaces the hand-written skew sequences used in benches and is the block that feeds the array in the integrated datapath.

Parameters:
- ARRAY_SIZE, 2, N: array dimension, lane count, operand matrices are N×N.
- DATA_WIDTH, 4, bits per operand element.
- DRAIN_CYCLES, 4, zero cycles driven after the last wavefront before `done` (must be ≥1).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- s_valid  input  1  load beat valid.
- s_ready  output  1  feeder can accept a load beat.
- s_a_col  input  ARRAY_SIZE*DATA_WIDTH  beat k: lane i = A[i][k].
- s_b_row  input  ARRAY_SIZE*DATA_WIDTH  beat k: lane j = B[k][j].
- input_left  output  ARRAY_SIZE*DATA_WIDTH  to array; lane i = row i.
- input_top  output  ARRAY_SIZE*DATA_WIDTH  to array; lane j = column j.
- busy  output  1  high in STREAM and DRAIN.
- done  output  1  one-cycle pulse at end of drain.

Behaviour:
- Lane 0 occupies bits [DATA_WIDTH-1:0] on all vector ports; lane i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- All outputs are registered.
- Reset values: `input_left`=0, `input_top`=0, `busy`=0, `done`=0, `s_ready`=1, state=LOAD, all counters=0. Buffer contents need not be cleared.
- FSM:
  - LOAD:
    - `s_ready`=1.
    - Each cycle with `s_valid` high is one beat k, where k is the beat counter (0..N-1).
    - The beat writes a_buf[i][k] and b_buf[k][j].
    - On accepting beat N-1, go to STREAM with t=0.
  - STREAM:
    - `s_ready`=0.
    - Each cycle, register wavefront t:
      - left lane i = A[i][t-i] if 0≤t-i<N, else 0.
      - top lane j = B[t-j][j] if 0≤t-j<N, else 0.
    - After t=2N-2, go to DRAIN.
  - DRAIN:
    - Outputs are 0.
    - Count DRAIN_CYCLES cycles, then go to LOAD.
    - `done`=1 for exactly the first cycle back in LOAD, with `s_ready`=1 in that same cycle.
- Latency: if the final beat is accepted at edge e0, wavefront t is on the ports after edge e0+1+t. The last wavefront is present after edge e0+2N-1. `done` is high after edge e0+2N-1+DRAIN_CYCLES.
- Skew index arithmetic uses unsigned counters of $clog2(2N) bits; negative t-i is detected by compare, with no wrap.
- `s_valid` while `s_ready`=0 is ignored; data is not captured.
- Back-to-back matrices: a beat presented in the `done` cycle is accepted.
- Asynchronous reset mid-STREAM or mid-DRAIN: immediately return to LOAD, zero the outputs, and discard partial beats. `done` is not asserted.

Optional Feature:
- Macro: SYSTOLIC_FEEDER_CLR_EN.
- Defined: adds output port `array_clr` (1 bit, reset 0). It is high for exactly one cycle, after edge e0, one cycle before wavefront 0, so array accumulators can be cleared without global reset.
- Undefined: the port and its logic are absent; the array must be reset between matrices.

Decomposition:
- Package `systolic_pkg`:
  - feeder state enum (LOAD, STREAM, DRAIN).
  - function computing the skew counter width from ARRAY_SIZE.
  - default ARRAY_SIZE and DATA_WIDTH constants, shared with `systolic`.
- One natural sub-module: `skew_lane_mux`. It selects buffer element [t-i] for one lane, or 0, and is instantiated 2N times (left and top).

Test Plan:
- Reset and load:
  - Stimulus: N=2, W=4. Load beats s_a_col={2,1} then {2,1}, and s_b_row={2,1} then {2,1}.
  - Required response: `input_left`/`input_top` sequence = {0,1}, {2,1}, {2,0}, then {0,0}. `busy` is high for 3+DRAIN_CYCLES cycles. `done` is high exactly once.
- Backpressure:
  - Stimulus: hold `s_valid`=1 with changing data during STREAM.
  - Required response: `s_ready`=0, and the buffers are unchanged (same wavefronts as the previous test).
- Gapped loading:
  - Stimulus: `s_valid` toggled 1,0,0,1.
  - Required response: exactly 2 beats are captured, and STREAM starts only after the second.
- Back-to-back:
  - Stimulus: present beat 0 of the next matrix in the `done` cycle.
  - Required response: the beat is accepted, and the second run's wavefronts match its own data.
- Reset mid-STREAM:
  - Stimulus: assert `reset` after wavefront 1.
  - Required response: outputs are 0 immediately (asynchronous), `s_ready`=1 after release, and no `done` pulse.
- With SYSTOLIC_FEEDER_CLR_EN defined:
  - Required response: `array_clr` pulses one cycle before wavefront {0,1} and nowhere else.
